// File: rtl/video_tgen_sync.sv
// video_tgen_sync: programmable video timing generator that locks an AXI-Stream pixel source to DE/HSYNC/VSYNC.
module video_tgen_sync #(
    parameter int                     PIXEL_WIDTH = 24,
    parameter int                     H_WIDTH     = 12,
    parameter int                     V_WIDTH     = 12,
    parameter logic [4*H_WIDTH-1:0]   DEF_H       = {H_WIDTH'(2080), H_WIDTH'(1952), H_WIDTH'(1920), H_WIDTH'(1920)},
    parameter logic [4*V_WIDTH-1:0]   DEF_V       = {V_WIDTH'(1111), V_WIDTH'(1088), V_WIDTH'(1083), V_WIDTH'(1080)},
    parameter logic                   HS_POL      = 1'b1,
    parameter logic                   VS_POL      = 1'b0,
    parameter logic [PIXEL_WIDTH-1:0] FILL_COLOR  = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic                   cfg_we_i,
    input  logic [4*H_WIDTH-1:0]   cfg_h_i,
    input  logic [4*V_WIDTH-1:0]   cfg_v_i,
    input  logic                   in_axis_tvalid,
    output logic                   in_axis_tready,
    input  logic [PIXEL_WIDTH-1:0] in_axis_tdata,
    input  logic                   in_axis_tuser,
    output logic                   vid_de_o,
    output logic                   vid_hs_o,
    output logic                   vid_vs_o,
    output logic [PIXEL_WIDTH-1:0] vid_data_o,
    output logic                   vid_sof_o,
    output logic                   underflow_o,
    output logic                   locked_o
);
    typedef enum logic [1:0] {IDLE, SEEK, RUN} state_t;
    state_t state, state_nxt;
    logic [4*H_WIDTH-1:0] h_cfg, h_shadow;
    logic [4*V_WIDTH-1:0] v_cfg, v_shadow;
    logic [H_WIDTH-1:0] h_cnt, h_act, h_ss, h_se, h_tot;
    logic [V_WIDTH-1:0] v_cnt, v_act, v_ss, v_se, v_tot;
    logic running, h_end, v_end, last, first, active, head_sof, lose, take, starve;
    logic [PIXEL_WIDTH-1:0] data_nxt;

    assign {h_tot, h_se, h_ss, h_act} = h_cfg;
    assign {v_tot, v_se, v_ss, v_act} = v_cfg;
    assign running  = state != IDLE;
    assign h_end    = h_cnt == h_tot - H_WIDTH'(1);
    assign v_end    = v_cnt == v_tot - V_WIDTH'(1);
    assign last     = h_end && v_end;
    assign first    = h_cnt == '0 && v_cnt == '0;
    assign active   = h_cnt < h_act && v_cnt < v_act;
    assign head_sof = in_axis_tvalid && in_axis_tuser;
    // In RUN the stream stays aligned only while SOF appears exactly at (0,0)
    assign lose     = active && (first ? !head_sof : head_sof);
    assign locked_o = state == RUN;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE                      ? (enable_i ? SEEK : IDLE) :
                    last && !enable_i                  ? IDLE :
                    state == SEEK && last && head_sof  ? RUN  :
                    state == RUN && lose               ? SEEK : state;
    end

    always_comb begin
        in_axis_tready = state == SEEK ? !in_axis_tuser : locked_o && active && (in_axis_tuser == first);
        take           = in_axis_tvalid && in_axis_tready;
        starve         = locked_o && active && !in_axis_tvalid;
        data_nxt       = !active ? '0 : (locked_o && take) ? in_axis_tdata : FILL_COLOR;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_shadow    <= DEF_H;
            v_shadow    <= DEF_V;
            h_cfg       <= DEF_H;
            v_cfg       <= DEF_V;
            vid_de_o    <= 1'b0;
            vid_hs_o    <= ~HS_POL;
            vid_vs_o    <= ~VS_POL;
            vid_data_o  <= '0;
            vid_sof_o   <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                h_shadow <= cfg_h_i;
                v_shadow <= cfg_v_i;
            end
            // A write coinciding with the frame's last pixel takes effect immediately
            if (!running || last) begin
                h_cfg <= cfg_we_i ? cfg_h_i : h_shadow;
                v_cfg <= cfg_we_i ? cfg_v_i : v_shadow;
            end
            h_cnt       <= (!running || h_end) ? '0 : h_cnt + H_WIDTH'(1);
            v_cnt       <= !running ? '0 : h_end ? (v_end ? '0 : v_cnt + V_WIDTH'(1)) : v_cnt;
            vid_de_o    <= running && active;
            vid_hs_o    <= (running && h_cnt >= h_ss && h_cnt < h_se) ? HS_POL : ~HS_POL;
            vid_vs_o    <= (running && v_cnt >= v_ss && v_cnt < v_se) ? VS_POL : ~VS_POL;
            vid_data_o  <= running ? data_nxt : '0;
            vid_sof_o   <= running && first;
            underflow_o <= starve;
        end
    end
endmodule

// File: tb/tb_video_tgen_sync.sv
// tb_video_tgen_sync: directed bench with a frame-position model checking every cycle plus literal expectations.
module tb_video_tgen_sync;
    localparam logic [23:0] FILL = 24'hABCDEF;
    logic clk = 0, rst_n = 0, en = 0, cfg_we = 0;
    logic [47:0] cfg_h = '0, cfg_v = '0;
    logic tvalid = 0, tuser = 0, tready;
    logic [23:0] tdata = '0;
    logic de, hs, vs, sof, uf, locked;
    logic [23:0] data;

    video_tgen_sync #(
        .PIXEL_WIDTH(24), .H_WIDTH(12), .V_WIDTH(12),
        .DEF_H({12'd16, 12'd12, 12'd10, 12'd8}),
        .DEF_V({12'd8, 12'd6, 12'd5, 12'd4}),
        .HS_POL(1'b1), .VS_POL(1'b0), .FILL_COLOR(FILL)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .cfg_we_i(cfg_we),
        .cfg_h_i(cfg_h), .cfg_v_i(cfg_v),
        .in_axis_tvalid(tvalid), .in_axis_tready(tready), .in_axis_tdata(tdata), .in_axis_tuser(tuser),
        .vid_de_o(de), .vid_hs_o(hs), .vid_vs_o(vs), .vid_data_o(data),
        .vid_sof_o(sof), .underflow_o(uf), .locked_o(locked)
    );

    always #5 clk = ~clk;

    logic [24:0] q[$];
    bit gap;
    int tests, fails, cyc;
    int n_de, n_hs, n_vsl, n_uf, n_fill;
    logic [23:0] first_px;
    // model: frame position, run/lock flags, timing as {active,sync_start,sync_end,total}
    bit m_known, m_run, m_lock;
    int x, y;
    int hc[4], vc[4], hsh[4], vsh[4];
    int DH[4] = '{8, 10, 12, 16};
    int DV[4] = '{4, 5, 6, 8};
    logic e_de, e_hs, e_vs, e_sof, e_uf;
    logic [23:0] e_data;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic model();
        int ci_h[4], ci_v[4];
        bit act, zero, last, sofh, rdy, fire, lose;
        for (int k = 0; k < 4; k++) begin
            ci_h[k] = int'(cfg_h[k*12 +: 12]);
            ci_v[k] = int'(cfg_v[k*12 +: 12]);
        end
        act  = x < hc[0] && y < vc[0];
        zero = x == 0 && y == 0;
        last = x == hc[3] - 1 && y == vc[3] - 1;
        sofh = tvalid && tuser;
        rdy  = m_run && (m_lock ? act && (tuser == zero) : !tuser);
        if (m_known) chk("tready", tready, rdy);
        fire = tvalid && rdy;
        if (!rst_n) begin
            m_known = 1; m_run = 0; m_lock = 0; x = 0; y = 0;
            hc = DH; vc = DV; hsh = DH; vsh = DV;
            e_de = 0; e_hs = 0; e_vs = 1; e_data = '0; e_sof = 0; e_uf = 0;
            return;
        end
        e_de   = m_run && act;
        e_hs   = m_run && x >= hc[1] && x < hc[2];
        e_vs   = !(m_run && y >= vc[1] && y < vc[2]);
        e_sof  = m_run && zero;
        e_uf   = m_lock && act && !tvalid;
        e_data = !(m_run && act) ? 24'h0 : (m_lock && fire) ? tdata : FILL;
        lose   = m_lock && act && (sofh != zero);
        if (cfg_we) begin hsh = ci_h; vsh = ci_v; end
        if (m_run) begin
            if (last && !en) begin m_run = 0; m_lock = 0; end
            else if (!m_lock && last && sofh) m_lock = 1;
            else if (lose) m_lock = 0;
            if (x == hc[3] - 1) begin
                x = 0;
                y = (y == vc[3] - 1) ? 0 : y + 1;
            end else x++;
            if (last) begin hc = hsh; vc = vsh; end
        end else begin
            hc = hsh; vc = vsh; m_run = en;
        end
    endtask

    task automatic step();
        bit took;
        tvalid = q.size() > 0 && !gap;
        if (tvalid) begin tuser = q[0][24]; tdata = q[0][23:0]; end
        else begin tuser = 0; tdata = '0; end
        #1;
        model();
        took = tvalid && tready;
        @(posedge clk); #1;
        cyc++;
        if (m_known) begin
            chk("de", de, e_de); chk("hs", hs, e_hs); chk("vs", vs, e_vs);
            chk("data", data, e_data); chk("sof", sof, e_sof); chk("uf", uf, e_uf);
            chk("locked", locked, m_lock);
        end
        if (took) void'(q.pop_front());
        if (de) begin n_de++; if (n_de == 1) first_px = data; if (data == FILL) n_fill++; end
        if (hs) n_hs++;
        if (!vs) n_vsl++;
        if (uf) n_uf++;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic clr();
        n_de = 0; n_hs = 0; n_vsl = 0; n_uf = 0; n_fill = 0; first_px = 'x;
    endtask

    task automatic push_frame(logic [23:0] base, int n);
        for (int i = 0; i < n; i++) q.push_back({i == 0, base + 24'(i)});
    endtask

    task automatic push_junk(int n);
        for (int i = 0; i < n; i++) q.push_back({1'b0, 24'hEE0000 + 24'(i)});
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_de"}, de, 0); chk({tag, "_hs"}, hs, 0); chk({tag, "_vs"}, vs, 1);
        chk({tag, "_data"}, data, 0); chk({tag, "_sof"}, sof, 0); chk({tag, "_uf"}, uf, 0);
        chk({tag, "_lock"}, locked, 0); chk({tag, "_tready"}, tready, 0);
    endtask

    initial begin
        run(3);
        chk_reset_outs("rst");
        rst_n = 1;
        run(2);
        push_frame(24'h100000, 32); push_frame(24'h200000, 32); push_frame(24'h300000, 32);
        push_frame(24'h400000, 11); push_frame(24'h500000, 32); push_frame(24'h600000, 32);
        push_frame(24'h700000, 16); push_frame(24'h800000, 16);
        // basic lock and timing
        en = 1;
        run(128);
        chk("lock_pre", locked, 0);
        run(1);
        chk("lock_rise", locked, 1);
        clr(); run(128);
        chk("f1_de", n_de, 32); chk("f1_hs", n_hs, 16); chk("f1_vsl", n_vsl, 16);
        chk("f1_fill", n_fill, 0); chk("f1_uf", n_uf, 0); chk("f1_first", first_px, 24'h100000);
        // underflow: three starved pixels, then misaligned SOF check
        clr(); run(2); gap = 1; run(3); gap = 0; run(123);
        chk("uf_cnt", n_uf, 3); chk("uf_fill", n_fill, 3); chk("uf_de", n_de, 32); chk("uf_lock", locked, 1);
        run(1);
        chk("uf_lost", locked, 0);
        run(127);
        chk("uf_relock", locked, 1);
        clr(); run(128);
        chk("uf_first", first_px, 24'h300000); chk("uf_fill2", n_fill, 0);
        // early SOF at (3,1)
        clr(); run(19);
        chk("early_pre", locked, 1);
        run(1);
        chk("early_lost", locked, 0);
        run(108);
        chk("early_relock", locked, 1); chk("early_fill", n_fill, 21);
        clr(); run(128);
        chk("early_first", first_px, 24'h500000); chk("early_fill2", n_fill, 0);
        // mid-frame config write, h_active=4
        clr(); run(50);
        cfg_h = {12'd16, 12'd12, 12'd10, 12'd4}; cfg_v = {12'd8, 12'd6, 12'd5, 12'd4}; cfg_we = 1;
        run(1);
        cfg_we = 0;
        run(77);
        chk("cfg_old_de", n_de, 32); chk("cfg_lock", locked, 1);
        clr(); run(128);
        chk("cfg_new_de", n_de, 16); chk("cfg_fill", n_fill, 0);
        chk("cfg_first", first_px, 24'h700000); chk("cfg_lock2", locked, 1);
        // enable clear mid-frame
        clr(); run(40); en = 0; run(88);
        chk("en_idle", locked, 0); chk("en_de", n_de, 16);
        run(1);
        chk("idle_de", de, 0); chk("idle_hs", hs, 0); chk("idle_vs", vs, 1);
        clr(); run(20);
        chk("idle_nde", n_de, 0); chk("idle_nhs", n_hs, 0); chk("idle_nvsl", n_vsl, 0);
        // reset mid-line, then junk before SOF
        push_frame(24'h900000, 16);
        en = 1;
        run(129);
        chk("rl_lock", locked, 1);
        run(20);
        rst_n = 0;
        run(1);
        chk_reset_outs("mid_rst");
        rst_n = 1;
        q.delete();
        push_junk(5); push_frame(24'hA00000, 32);
        run(11);
        chk("junk_gone", q.size(), 32); chk("junk_lock", locked, 0);
        run(117);
        chk("junk_pre", locked, 0);
        run(1);
        chk("junk_relock", locked, 1);
        clr(); run(128);
        chk("junk_first", first_px, 24'hA00000); chk("junk_de", n_de, 32); chk("junk_fill", n_fill, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
